axis_packet_summer: RTL

AXIS_PACKET_SUMMER -- requirements
Module: axis_packet_summer

---
 rtl/axis_summer_pkg.sv | 13 +
 rtl/axis_sync_fifo.sv | 60 ++++++
 rtl/axis_packet_summer.sv | 109 ++++++++++
 3 files changed

// File: rtl/axis_summer_pkg.sv
// rtl/axis_summer_pkg.sv - shared state type and default sizes for axis_packet_summer
package axis_summer_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ACC_W  = 48;
    localparam int DEF_DEPTH  = 4;

    typedef enum logic {
        ACCUM  = 1'b0,
        OUTPUT = 1'b1
    } sum_state_e;

endpackage

// File: rtl/axis_sync_fifo.sv
// rtl/axis_sync_fifo.sv - single-clock FIFO with registered occupancy, full, empty and count
module axis_sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         pop_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o     = (count_q == (AW+1)'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign pop_data_o = mem_q[rd_ptr_q];

    // Storage is not reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/axis_packet_summer.sv
// rtl/axis_packet_summer.sv - sums each input packet and emits the total on a result stream
module axis_packet_summer
    import axis_summer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int SAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    input  logic              s_tlast,
    output logic              s_tready,
    output logic [ACC_W-1:0]  m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tuser,
    output logic [ACC_W-1:0]  result,
    output logic [15:0]       pkt_count
);

    localparam int CW = $clog2(DEPTH) + 1;

    sum_state_e       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] result_q, result_d;
    logic             ovf_q, ovf_d;
    logic [15:0]      pkt_count_q, pkt_count_d;

    logic             fifo_full;
    logic             fifo_empty;
    logic [DATA_W:0]  fifo_rd;
    logic [CW-1:0]    unused_fifo_count;
    logic             pop;
    logic             handshake;
    logic [ACC_W:0]   sum_ext;

    // Gating with rst keeps s_tready low while reset is held.
    assign s_tready = rst && !fifo_full;

    axis_sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst),
        .push_i      (s_tvalid && s_tready),
        .push_data_i ({s_tlast, s_tdata}),
        .pop_i       (pop),
        .pop_data_o  (fifo_rd),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (unused_fifo_count)
    );

    assign pop       = (state_q == ACCUM) && !fifo_empty;
    assign handshake = (state_q == OUTPUT) && m_tready;
    assign sum_ext   = {1'b0, acc_q} + {{(ACC_W + 1 - DATA_W){1'b0}}, fifo_rd[DATA_W-1:0]};

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        result_d    = result_q;
        pkt_count_d = pkt_count_q;
        if (pop) begin
            ovf_d = ovf_q || sum_ext[ACC_W];
            if (sum_ext[ACC_W] && (SAT != 0)) begin
                acc_d = '1;
            end else begin
                acc_d = sum_ext[ACC_W-1:0];
            end
            if (fifo_rd[DATA_W]) begin
                state_d = OUTPUT;
            end
        end else if (handshake) begin
            result_d    = acc_q;
            pkt_count_d = pkt_count_q + 16'd1;
            acc_d       = '0;
            ovf_d       = 1'b0;
            state_d     = ACCUM;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            result_q    <= '0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            result_q    <= result_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    assign m_tvalid  = (state_q == OUTPUT);
    assign m_tdata   = m_tvalid ? acc_q : '0;
    assign m_tuser   = m_tvalid && ovf_q;
    assign result    = result_q;
    assign pkt_count = pkt_count_q;

endmodule
